// File: rtl/reduce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reduce_pkg
// Brief    : Op encodings and elaboration helpers for the reduction tree.
// Revision : 1.0
// ============================================================================
package reduce_pkg;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    // Neutral padding bit: 1 only for AND; OR, XOR and the reserved code use 0.
    function automatic logic identity(input logic [1:0] op);
        return (op == OP_AND);
    endfunction

    function automatic int tree_stages(input int width, input int radix);
        int span;
        int stages;
        span   = 1;
        stages = 0;
        for (int i = 0; i < 32; i++) begin
            if (span < width) begin
                span   = span * radix;
                stages = stages + 1;
            end
        end
        return stages;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reduce_stage.sv
`default_nettype none
// ============================================================================
// Module   : reduce_stage
// Brief    : One registered tree level; IN_W/RADIX nodes, op and valid travel along.
// Revision : 1.0
// ============================================================================
module reduce_stage
    import reduce_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int RADIX = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic [IN_W-1:0]         i_data,
    input  logic [1:0]              i_op,
    input  logic                    i_valid,
    output logic [IN_W/RADIX-1:0]   o_data,
    output logic [1:0]              o_op,
    output logic                    o_valid
);

    localparam int OUT_W = IN_W / RADIX;

    logic [OUT_W-1:0] w_node;
    logic [OUT_W-1:0] r_data;
    logic [1:0]       r_op;
    logic             r_valid;

    function automatic logic node_reduce(input logic [RADIX-1:0] bits, input logic [1:0] op);
        logic res;
        case (op)
            OP_AND:  res = &bits;
            OP_XOR:  res = ^bits;
            default: res = |bits;
        endcase
        return res;
    endfunction

    for (genvar n = 0; n < OUT_W; n++) begin : g_node
        assign w_node[n] = node_reduce(i_data[n*RADIX +: RADIX], i_op);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_op    <= OP_OR;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_data  <= w_node;
            r_op    <= i_op;
        end
    end

    assign o_data  = r_data;
    assign o_op    = r_op;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/reduce_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module   : reduce_tree_pipe
// Brief    : Pipelined OR/AND/XOR reduction tree with valid/ready and hit counter.
// Revision : 1.0
// ============================================================================
module reduce_tree_pipe
    import reduce_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int RADIX   = 2,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_op,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_result,
    output logic [1:0]         out_op,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               clear,
    output logic [COUNT_W-1:0] hit_count
);

    localparam int STAGES = tree_stages(WIDTH, RADIX);
    localparam int PAD_W  = RADIX ** STAGES;

    // Bit offset of tree level k inside the flattened level vector.
    function automatic int level_off(input int k);
        int off;
        off = 0;
        for (int j = 0; j < k; j++) begin
            off = off + PAD_W / (RADIX ** j);
        end
        return off;
    endfunction

    localparam int LVL_W = level_off(STAGES + 1);
    localparam logic [COUNT_W-1:0] c_hit_max = '1;

    logic [LVL_W-1:0]   w_lvl;
    logic [1:0]         w_op  [0:STAGES];
    logic               w_vld [0:STAGES];
    logic               w_adv;
    logic [COUNT_W-1:0] r_hit_count;

    if (PAD_W > WIDTH) begin : g_pad
        assign w_lvl[PAD_W-1:0] = {{(PAD_W-WIDTH){identity(in_op)}}, in_data};
    end else begin : g_nopad
        assign w_lvl[PAD_W-1:0] = in_data;
    end

    assign w_op[0]  = in_op;
    assign w_vld[0] = in_valid;

    // Single global advance: bubbles move with the data, never squeezed out.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv && !reset;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IN_W = PAD_W / (RADIX ** k);
        reduce_stage #(
            .IN_W  (IN_W),
            .RADIX (RADIX)
        ) u_stage (
            .clk     (clk),
            .rst     (reset),
            .i_en    (w_adv),
            .i_data  (w_lvl[level_off(k) +: IN_W]),
            .i_op    (w_op[k]),
            .i_valid (w_vld[k]),
            .o_data  (w_lvl[level_off(k+1) +: IN_W/RADIX]),
            .o_op    (w_op[k+1]),
            .o_valid (w_vld[k+1])
        );
    end

    assign out_result = w_lvl[LVL_W-1];
    assign out_op     = w_op[STAGES];
    assign out_valid  = w_vld[STAGES];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_hit_count <= '0;
        end else if (out_valid && out_ready && out_result && (r_hit_count != c_hit_max)) begin
            r_hit_count <= r_hit_count + COUNT_W'(1);
        end
    end

    assign hit_count = r_hit_count;

endmodule
`default_nettype wire

// File: doc/reduce_tree_pipe.md
Name: reduce_tree_pipe

Overview:
- Parametrised, pipelined N-input reduction tree. Generalises the fixed 8-input OR gate to any WIDTH, any tree RADIX, and three selectable operations (OR/AND/XOR).
- Adds valid/ready flow control and a saturating hit counter.
- Serves the Hack datapath for zero/any flags on wide buses (ALU zr, interrupt-pending detect, memory-mapped status words).
- One registered tree level per pipeline stage, so wide reductions meet timing on the FPGA.

Parameters:
- WIDTH, 16, number of input bits; legal range 2..256.
- RADIX, 2, inputs per tree node; legal values 2 or 4.
- COUNT_W, 16, width of hit_count.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  vector to reduce.
- in_op  input  2  operation, sampled with in_data: 00 OR, 01 AND, 10 XOR, 11 reserved (treated as OR).
- in_valid  input  1  in_data/in_op are valid.
- in_ready  output  1  block accepts input this cycle.
- out_result  output  1  reduction result.
- out_op  output  2  op that produced out_result.
- out_valid  output  1  out_result valid.
- out_ready  input  1  consumer accepts result.
- clear  input  1  synchronous clear of hit_count.
- hit_count  output  COUNT_W  number of accepted results equal to 1.

Behaviour:
- STAGES = ceil(log_RADIX(WIDTH)); WIDTH=16 gives 4 for RADIX 2 and 2 for RADIX 4.
- Input padding: the vector is padded to RADIX^STAGES bits with the identity element: 0 for OR/XOR, 1 for AND. Padding must never change the result.
- Stage k registers one tree level, its op, and a valid bit. The op travels with the data.
- Global advance: adv = !out_valid || out_ready.
  - All stages shift when adv=1.
  - All stages hold when adv=0.
  - Bubbles are not compressed.
- in_ready = adv && !reset, combinational.
- Accept: in_valid && in_ready. Stage-0 valid loads in_valid when adv=1.
- Latency: accepted input appears at out_valid exactly STAGES cycles later with no stall. Throughput is 1 result/cycle when out_ready is held high.
- Stall: out_result/out_op/out_valid stay stable while out_valid=1 and out_ready=0. No input is accepted and no beat is lost or duplicated.
- Reset (synchronous, and may land mid-operation): all valid bits 0, out_result 0, out_op 00, hit_count 0. In-flight data is discarded. in_ready=0 during the reset cycle and 1 on the first cycle after.
- hit_count:
  - +1 on each handshake (out_valid && out_ready) with out_result=1.
  - Saturates at 2^COUNT_W-1 and does not wrap.
  - clear sets it to 0; clear wins over a simultaneous increment.
  - clear does not affect the pipeline.
- Data registers of invalid stages may hold stale values. Only valid-qualified outputs are meaningful, except that out_result reads 0 after reset.

Decomposition:
- Shared package reduce_pkg:
  - op encodings OP_OR=2'b00, OP_AND=2'b01, OP_XOR=2'b10.
  - function identity(op).
  - function tree_stages(width, radix).
- Sub-module reduce_stage (parameters IN_W, RADIX):
  - one registered level: IN_W/RADIX nodes applying op.
  - hold enable, valid and op pass-through.
- Top instantiates STAGES reduce_stage via generate and owns the handshake and hit_count.

Test Plan:
- Reset then WIDTH=16, RADIX=2: in_data=16'h0000 OP_OR, then 16'h0100 OP_OR, out_ready=1 -> out_result 0 at cycle 4, 1 at cycle 5; hit_count=1.
- Ops on 16'hFFFF OP_AND, 16'hFFFE OP_AND, 16'h0007 OP_XOR, 16'h0003 OP_XOR back-to-back -> results 1,0,1,0 on consecutive cycles; out_op matches each; hit_count=2.
- Padding, WIDTH=5 RADIX=4: 5'b11111 OP_AND -> 1; 5'b00000 OP_OR -> 0; 5'b10000 OP_XOR -> 1; latency 2.
- Backpressure: stream 8 random words, out_ready low for 3 cycles mid-stream -> in_ready low during stall, outputs held stable, all 8 results in order against the reference model, none lost or duplicated.
- Saturation/clear, COUNT_W=2: 5 accepted results of 1 -> hit_count 3 (holds); clear together with a result of 1 -> hit_count 0 next cycle.
- Reset mid-flight: 3 words in the pipeline, reset for 1 cycle -> out_valid 0, hit_count 0, no stale results emerge; the next accepted word emerges after STAGES cycles.
